// File: rtl/spi_pkg.sv
// Shared types and line-level constants for the SPI mode-0 slave.
package spi_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} spi_state_e;

    localparam int   SPI_WIDTH = 8;
    localparam logic SS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchroniser with one extra delayed copy for edge detection.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB-first, fully oversampled on clk, with a one-entry
// valid/ready transmit buffer and a one-cycle receive strobe.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             underrun,
    output logic             busy
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (
        .clk(clk), .rst(rst), .d_i(SCLK),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SS_IDLE)) u_ss (
        .clk(clk), .rst(rst), .d_i(SS),
        .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_mosi (
        .clk(clk), .rst(rst), .d_i(MOSI),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    assign unused_sync = sclk_lvl ^ ss_lvl ^ mosi_rise ^ mosi_fall;

    spi_state_e       state_q;
    logic [CNT_W-1:0] bitcnt_q;
    logic [WIDTH-1:0] rx_shift_q, tx_shift_q, rx_data_q, buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             miso_q, rx_valid_q, underrun_q;
    logic             load_frame, tx_hs;

    // A frame (re)load happens on SS entry, or at a frame boundary while SS stays low.
    assign load_frame = (state_q == ST_IDLE && ss_fall) ||
                        (state_q == ST_ACTIVE && !ss_rise && sclk_fall && bitcnt_q == '0);
    assign tx_hs      = tx_valid && !buf_full_q;

    // A handshake landing on a reload cycle fills the buffer for the following frame.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (load_frame && buf_full_q) buf_full_d = 1'b0;
        if (tx_hs) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            if (load_frame) begin
                tx_shift_q <= buf_full_q ? buf_q : '0;
                miso_q     <= buf_full_q & buf_q[WIDTH-1];
                underrun_q <= !buf_full_q;
            end
            case (state_q)
                ST_IDLE: begin
                    miso_q <= load_frame & buf_full_q & buf_q[WIDTH-1];
                    if (ss_fall) begin
                        state_q  <= ST_ACTIVE;
                        bitcnt_q <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        state_q    <= ST_IDLE;
                        bitcnt_q   <= '0;
                        rx_shift_q <= '0;
                        tx_shift_q <= '0;
                        miso_q     <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[WIDTH-2:0], mosi_lvl};
                        if (bitcnt_q == LAST_BIT) begin
                            rx_data_q  <= {rx_shift_q[WIDTH-2:0], mosi_lvl};
                            rx_valid_q <= 1'b1;
                            bitcnt_q   <= '0;
                        end else begin
                            bitcnt_q <= bitcnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall && bitcnt_q != '0) begin
                        tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                        miso_q     <= tx_shift_q[WIDTH-2];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign MISO     = miso_q;
    assign tx_ready = !buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign busy     = (state_q == ST_ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// Randomised scoreboard bench for spi_slave driving a mode-0 master at clk/8.
module tb_spi_slave;
    localparam int W    = 8;
    localparam int HALF = 4;

    logic         clk, rst, SCLK, SS, MOSI, MISO;
    logic [W-1:0] tx_data, rx_data;
    logic         tx_valid, tx_ready, rx_valid, underrun, busy;

    spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int underrun_seen = 0;
    int underrun_exp = 0;
    logic [W-1:0] exp_rx[$];
    logic         mbuf_full = 1'b0;
    logic [W-1:0] mbuf = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every receive strobe must match the oldest frame the master sent.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
                end
            end
            if (underrun) underrun_seen++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) check("tx_ready_timeout", 32'd0, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        mbuf      = d;
        mbuf_full = 1'b1;
    endtask

    // Reference: a frame transmits the buffered word if one is waiting, else zeros.
    task automatic model_start(output logic [W-1:0] e);
        if (mbuf_full) begin
            e = mbuf;
            mbuf_full = 1'b0;
        end else begin
            e = '0;
            underrun_exp++;
        end
    endtask

    task automatic ss_begin();
        SS = 1'b0;
        wait_clks(HALF);
        check("busy_active", {31'd0, busy}, 32'd1);
        check("tx_ready_after_ssfall", {31'd0, tx_ready}, {31'd0, !mbuf_full});
    endtask

    task automatic shift_frame(input logic [W-1:0] mo, input bit hold, output logic [W-1:0] mi);
        for (int i = W - 1; i >= 0; i--) begin
            MOSI = mo[i];
            wait_clks(HALF);
            mi[i] = MISO;
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
            if (i == 0 && !hold) SS = 1'b1;
        end
    endtask

    task automatic end_frame();
        wait_clks(2 * HALF);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("miso_idle", {31'd0, MISO}, 32'd0);
        check("underrun_count", underrun_seen, underrun_exp);
    endtask

    task automatic run_frame(input logic [W-1:0] mo);
        logic [W-1:0] e, mi;
        model_start(e);
        exp_rx.push_back(mo);
        ss_begin();
        shift_frame(mo, 1'b0, mi);
        check("miso_frame", {24'd0, mi}, {24'd0, e});
        end_frame();
    endtask

    initial begin
        logic [W-1:0] e1, e2, mi1, mi2, d;
        rst = 1'b1; SCLK = 1'b0; SS = 1'b1; MOSI = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        wait_clks(3);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        wait_clks(3);

        // Basic transfer: buffer 0xA5, master sends 0x3C.
        load_tx(8'hA5);
        run_frame(8'h3C);

        // Back-to-back frames with SS held low.
        load_tx(8'h81);
        model_start(e1);
        exp_rx.push_back(8'h11);
        ss_begin();
        load_tx(8'h7E);
        shift_frame(8'h11, 1'b1, mi1);
        model_start(e2);
        exp_rx.push_back(8'h22);
        shift_frame(8'h22, 1'b0, mi2);
        check("b2b_miso0", {24'd0, mi1}, {24'd0, e1});
        check("b2b_miso1", {24'd0, mi2}, {24'd0, e2});
        end_frame();

        // Empty buffer: underrun, zeros on MISO, receive still works.
        run_frame(8'hFF);

        // Partial frame discarded, then a full one.
        model_start(e1);
        SS = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            wait_clks(HALF);
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        wait_clks(HALF);
        SS = 1'b1;
        end_frame();
        run_frame(8'h96);

        // Handshake in the ss_fall cycle with an empty buffer.
        model_start(e1);
        exp_rx.push_back(8'hC3);
        SS = 1'b0;
        wait_clks(2);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        mbuf = 8'h5A;
        mbuf_full = 1'b1;
        wait_clks(2);
        check("hs_tx_ready", {31'd0, tx_ready}, 32'd0);
        shift_frame(8'hC3, 1'b0, mi1);
        check("hs_miso_underrun", {24'd0, mi1}, {24'd0, e1});
        end_frame();
        run_frame(8'h0F);

        // Randomised frames with randomly present transmit data.
        for (int n = 0; n < 12; n++) begin
            d = W'($urandom);
            if ($urandom_range(0, 1) == 1) load_tx(W'($urandom));
            run_frame(d);
        end

        // Asynchronous reset mid-frame.
        load_tx(8'h33);
        SS = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_miso", {31'd0, MISO}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("arst_rx_data", {24'd0, rx_data}, 32'd0);
        check("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("arst_underrun", {31'd0, underrun}, 32'd0);
        SS = 1'b1;
        SCLK = 1'b0;
        mbuf_full = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        load_tx(8'hE7);
        run_frame(8'h5C);

        wait_clks(20);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
        check("underrun_total", underrun_seen, underrun_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
